// File: rtl/entropy_src_pkg.sv
// Shared types and constants for the entropy_src hardware interface requester.
package entropy_src_pkg;

  localparam int unsigned CSRNG_BUS_WIDTH = 384;
  localparam int unsigned DupChkW         = 64;

  typedef struct packed {
    logic es_req;
  } entropy_src_hw_if_req_t;

  typedef struct packed {
    logic                       es_ack;
    logic [CSRNG_BUS_WIDTH-1:0] es_bits;
    logic                       es_fips;
  } entropy_src_hw_if_rsp_t;

  // Sparse encodings, pairwise Hamming distance >= 3.
  typedef enum logic [4:0] {
    StIdle = 5'b00000,
    StReq  = 5'b00111,
    StHold = 5'b11001,
    StErr  = 5'b11110
  } req_state_e;

endpackage

// File: rtl/entropy_src_hw_if_req_tmr.sv
// Per-request timeout counter: saturating up-counter with clear/load and an
// expire flag raised on the last allowed cycle (threshold 0 never expires).
module entropy_src_hw_if_req_tmr #(
  parameter int unsigned TimeoutW = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [TimeoutW-1:0] load_val_i,
  input  logic                inc_i,
  input  logic [TimeoutW-1:0] thresh_i,
  output logic                expire_o
);

  logic [TimeoutW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (thresh_i != '0) && (cnt_q == thresh_i - 1'b1);

endmodule

// File: rtl/entropy_src_hw_if_req.sv
// Requester side of the entropy_src hardware interface with a one-entry seed buffer.
// Optional duplicate-seed check enabled by ENTROPY_SRC_HW_IF_REQ_DUP_CHK_EN.
module entropy_src_hw_if_req
  import entropy_src_pkg::*;
#(
  parameter int unsigned SeedW    = CSRNG_BUS_WIDTH,
  parameter int unsigned TimeoutW = 16,
  parameter logic        Prefetch = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   seed_req_i,
  input  logic [TimeoutW-1:0]    timeout_thresh_i,
  output entropy_src_hw_if_req_t entropy_src_hw_if_o,
  input  entropy_src_hw_if_rsp_t entropy_src_hw_if_i,
  output logic                   seed_valid_o,
  input  logic                   seed_ready_i,
  output logic [SeedW-1:0]       seed_o,
  output logic                   seed_fips_o,
  output logic                   busy_o,
  output logic                   timeout_err_o,
  output logic                   dup_err_o
);

  req_state_e       state_q, state_d;
  logic             req_q, vld_q, busy_q, terr_q, terr_d;
  logic [SeedW-1:0] seed_q, seed_d;
  logic             fips_q, fips_d;
  logic             ack, dup, expire, tmr_clr, tmr_inc;

  assign ack = entropy_src_hw_if_i.es_ack;

  entropy_src_hw_if_req_tmr #(
    .TimeoutW(TimeoutW)
  ) u_tmr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (tmr_clr),
    .load_i    (1'b0),
    .load_val_i('0),
    .inc_i     (tmr_inc),
    .thresh_i  (timeout_thresh_i),
    .expire_o  (expire)
  );

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    fips_d  = fips_q;
    terr_d  = terr_q;
    tmr_clr = 1'b1;
    tmr_inc = 1'b0;
    case (state_q)
      StIdle: begin
        if ((seed_req_i || Prefetch) && !terr_q) state_d = StReq;
      end
      StReq: begin
        tmr_clr = 1'b0;
        tmr_inc = 1'b1;
        if (ack) begin
          // A duplicate stays in Req with a fresh timeout window.
          tmr_clr = 1'b1;
          if (!dup) begin
            seed_d  = entropy_src_hw_if_i.es_bits[SeedW-1:0];
            fips_d  = entropy_src_hw_if_i.es_fips;
            state_d = StHold;
          end
        end else if (expire) begin
          terr_d  = 1'b1;
          state_d = StErr;
        end
      end
      StHold: begin
        if (seed_ready_i) begin
          seed_d  = '0;
          fips_d  = 1'b0;
          state_d = (seed_req_i || Prefetch) ? StReq : StIdle;
        end
      end
      StErr: ;
      default: begin
        state_d = StErr;
        terr_d  = 1'b1;
        seed_d  = '0;
        fips_d  = 1'b0;
      end
    endcase
    if (!enable_i) begin
      state_d = StIdle;
      seed_d  = '0;
      fips_d  = 1'b0;
      terr_d  = 1'b0;
      tmr_clr = 1'b1;
      tmr_inc = 1'b0;
    end
  end

  // Handshake outputs are registered copies of the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      seed_q  <= '0;
      fips_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == StReq);
      vld_q   <= (state_d == StHold);
      busy_q  <= (state_d == StReq);
      terr_q  <= terr_d;
      seed_q  <= seed_d;
      fips_q  <= fips_d;
    end
  end

`ifdef ENTROPY_SRC_HW_IF_REQ_DUP_CHK_EN
  logic [DupChkW-1:0] last_q;
  logic               last_vld_q, derr_q, take, dup_hit;

  assign dup     = last_vld_q && (entropy_src_hw_if_i.es_bits[DupChkW-1:0] == last_q);
  assign take    = enable_i && (state_q == StReq) && ack && !dup;
  assign dup_hit = enable_i && (state_q == StReq) && ack && dup;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
      derr_q     <= 1'b0;
    end else if (!enable_i) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
      derr_q     <= 1'b0;
    end else begin
      if (take) begin
        last_q     <= entropy_src_hw_if_i.es_bits[DupChkW-1:0];
        last_vld_q <= 1'b1;
      end
      if (dup_hit) derr_q <= 1'b1;
    end
  end

  assign dup_err_o = derr_q;
`else
  assign dup       = 1'b0;
  assign dup_err_o = 1'b0;
`endif

  assign entropy_src_hw_if_o.es_req = req_q;
  assign seed_valid_o  = vld_q;
  assign seed_o        = seed_q;
  assign seed_fips_o   = fips_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = terr_q;

endmodule

// File: doc/entropy_src_hw_if_req.md
Name: entropy_src_hw_if_req

Overview:
- Requester end of the entropy_src hardware entropy interface, used by consumers such as CSRNG.
- Drives es_req, captures the 384-bit es_bits and es_fips on es_ack, and holds them in a one-entry seed buffer.
- Delivers the buffered seed to a local consumer over a valid/ready handshake.
- Supervises each request with a timeout counter and can optionally prefetch the next seed.

Parameters:
- SeedW, 384 (entropy_src_pkg::CSRNG_BUS_WIDTH): seed width.
- TimeoutW, 16: timeout counter width.
- Prefetch, 1'b0: when 1, a new request is issued as soon as the buffer empties, without waiting for seed_req_i.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- enable_i  in  1  block enable; low forces Idle and flushes the buffer.
- seed_req_i  in  1  level; consumer wants a seed.
- timeout_thresh_i  in  TimeoutW  cycles allowed per request; 0 disables the timeout.
- entropy_src_hw_if_o  out  entropy_src_hw_if_req_t  es_req.
- entropy_src_hw_if_i  in  entropy_src_hw_if_rsp_t  es_ack, es_bits, es_fips.
- seed_valid_o  out  1  buffered seed available.
- seed_ready_i  in  1  consumer accepts the seed.
- seed_o  out  SeedW  buffered seed.
- seed_fips_o  out  1  FIPS flag of the buffered seed.
- busy_o  out  1  request outstanding.
- timeout_err_o  out  1  sticky timeout error.
- dup_err_o  out  1  sticky duplicate error; tied 0 without DUP_CHK.

Behaviour:
- Reset values:
  - All outputs 0; seed register 0; state Idle; counter 0.
- State Idle:
  - es_req=0, seed_valid_o=0.
  - Go to Req when enable_i && (seed_req_i || Prefetch) && !timeout_err_o.
- State Req:
  - es_req=1 (registered; asserted the cycle after the Idle->Req decision); busy_o=1.
  - Counter increments each cycle.
  - On es_ack=1: capture es_bits/es_fips into the seed register, clear the counter, go to Hold.
  - Capture-to-seed_valid_o latency is 1 cycle. es_req deasserts the same cycle Hold is entered, so it is low the cycle after the ack.
  - If timeout_thresh_i!=0 and counter==timeout_thresh_i-1 with no ack: set timeout_err_o, drop es_req, go to Err.
  - es_ack and timeout in the same cycle: the ack wins and no error is raised.
- State Hold:
  - seed_valid_o=1; seed_o and seed_fips_o stay stable until the handshake.
  - On seed_valid_o && seed_ready_i: clear seed_valid_o and the seed register (zeroised) the next cycle.
  - Then go to Req if (seed_req_i || Prefetch) && enable_i, otherwise Idle.
  - In Prefetch mode this gives at most one outstanding request plus zero buffered seeds at any time; there is no overlap of request and Hold.
- State Err:
  - es_req=0, seed_valid_o=0.
  - Leaves to Idle only on a low enable_i, which also clears timeout_err_o.
- enable_i low in any state:
  - Next cycle: state Idle, es_req=0, seed register zeroised, counter 0.
  - An es_ack arriving in the cycle enable_i is low is discarded.
- es_ack while not in Req: ignored; nothing is captured.
- Counter saturates at all-ones and does not wrap.
- Illegal state encoding: go to Err and set timeout_err_o. States are sparse-encoded (Hamming distance >=3).

Optional Feature:
- Macro: ENTROPY_SRC_HW_IF_REQ_DUP_CHK_EN.
- With the macro: the block keeps the low 64 bits of the last accepted seed.
- If a newly acked seed has identical low 64 bits:
  - The seed is discarded, not buffered.
  - dup_err_o is set (sticky; cleared by a low enable_i).
  - The block re-enters Req for a fresh seed.
- The first seed after reset or enable is never flagged.
- Without the macro: no comparison register; dup_err_o=0.

Decomposition:
- entropy_src_pkg holds:
  - the state enum and its sparse encodings;
  - SeedW default (CSRNG_BUS_WIDTH);
  - the DupChkW=64 constant.
- Natural sub-module: entropy_src_hw_if_req_tmr, the timeout counter with load, clear, saturate and expire outputs.
- The seed buffer and FSM remain in the top.

Test Plan:
- Basic request:
  - Stimulus: enable_i=1, seed_req_i=1, thresh=100; ack after 5 cycles with es_bits={6{64'hA5A5_0000_1234_5678}}, fips=1.
  - Response: es_req high for 5 cycles; seed_valid_o 1 cycle after the ack; seed_o equals the acked bits; busy_o falls.
- Backpressure:
  - Stimulus: seed_ready_i held 0 for 20 cycles, then pulsed.
  - Response: seed_o stable throughout; es_req=0 throughout; seed_valid_o=0 and seed_o=0 the cycle after the handshake.
- Timeout:
  - Stimulus: thresh=8, no ack.
  - Response: timeout_err_o rises after exactly 8 cycles of es_req; es_req drops; state Err; enable_i low then clears the error.
- Ack/timeout collision:
  - Stimulus: thresh=4, ack on the 4th es_req cycle.
  - Response: seed captured; timeout_err_o=0.
- Disable mid-request:
  - Stimulus: enable_i drops on request cycle 3, together with an ack.
  - Response: ack discarded; es_req=0 next cycle; seed_valid_o stays 0.
- Prefetch and duplicate check (Prefetch=1, macro defined):
  - Stimulus: two consecutive acks with low 64 bits 64'hDEAD_BEEF_0000_0001.
  - Response: dup_err_o=1; second seed never presented; a new es_req issued.
  - Without the macro the second seed is delivered.
